// File: rtl/alu_console.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_console: operand registers, capture history and LCD name/value mux.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module alu_console #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 5,
  parameter int HIST_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [1:0]        input_sel,
  input  logic              input_valid,
  input  logic [31:0]       input_value,
  input  logic              capture_btn,
  input  logic [5:0]        display_number,
  output logic              display_valid,
  output logic [39:0]       display_name,
  output logic [31:0]       display_value,
  output logic [CTRL_W-1:0] alu_control,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [5:0]        hist_count
);

  localparam int c_ptr_w = $clog2(HIST_DEPTH);

  logic [CTRL_W-1:0]  r_ctrl;
  logic [DATA_W-1:0]  r_src1;
  logic [DATA_W-1:0]  r_src2;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [5:0]         r_hist_count;
  logic [CNT_W-1:0]   r_cap_cnt;
  logic               r_btn_meta;
  logic               r_btn_sync;
  logic               r_btn_prev;
  logic [DATA_W-1:0]  r_hist [HIST_DEPTH];
  logic               r_disp_valid;
  logic [39:0]        r_disp_name;
  logic [31:0]        r_disp_value;

  logic               w_btn_pulse;
  logic               w_hist_cmd;
  logic               w_clear;
  logic               w_capture;
  logic [5:0]         w_k;
  logic               w_in_hist;
  logic [c_ptr_w-1:0] w_rd_idx;
  logic [39:0]        w_his_name;
  logic               w_disp_valid;
  logic [39:0]        w_disp_name;
  logic [31:0]        w_disp_value;

  assign w_btn_pulse = r_btn_sync & ~r_btn_prev;
  assign w_hist_cmd  = input_valid && (input_sel == 2'b01);
  assign w_clear     = w_hist_cmd && (input_value == 32'd0);
  // Clear beats any coincident button pulse; a pulse plus a command is one capture.
  assign w_capture   = (w_btn_pulse || w_hist_cmd) && !w_clear;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ctrl       <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_wr_ptr     <= '0;
      r_hist_count <= '0;
      r_cap_cnt    <= '0;
      r_btn_meta   <= 1'b0;
      r_btn_sync   <= 1'b0;
      r_btn_prev   <= 1'b0;
    end else begin
      r_btn_meta <= capture_btn;
      r_btn_sync <= r_btn_meta;
      r_btn_prev <= r_btn_sync;
      if (input_valid) begin
        case (input_sel)
          2'b00:   r_ctrl <= input_value[CTRL_W-1:0];
          2'b10:   r_src1 <= input_value[DATA_W-1:0];
          2'b11:   r_src2 <= input_value[DATA_W-1:0];
          default: ;
        endcase
      end
      if (w_clear) begin
        r_wr_ptr     <= '0;
        r_hist_count <= '0;
        r_cap_cnt    <= '0;
      end else if (w_capture) begin
        r_wr_ptr  <= r_wr_ptr + c_ptr_w'(1);
        r_cap_cnt <= r_cap_cnt + CNT_W'(1);
        if (r_hist_count != 6'(HIST_DEPTH))
          r_hist_count <= r_hist_count + 6'd1;
      end
    end
  end

  // History storage is not reset; stale entries are hidden by the count.
  always_ff @(posedge clk) begin
    if (resetn && w_capture)
      r_hist[r_wr_ptr] <= alu_result;
  end

  assign w_k        = display_number - 6'd7;
  assign w_in_hist  = (display_number >= 6'd7) && (display_number <= 6'(6 + HIST_DEPTH));
  assign w_rd_idx   = r_wr_ptr - c_ptr_w'(1) - w_k[c_ptr_w-1:0];
  assign w_his_name = {"HIS", 8'h30 + 8'(w_k / 6'd10), 8'h30 + 8'(w_k % 6'd10)};

  always_comb begin
    w_disp_valid = 1'b0;
    w_disp_name  = '0;
    w_disp_value = '0;
    case (display_number)
      6'd1: begin w_disp_valid = 1'b1; w_disp_name = "SRC_1"; w_disp_value = 32'(r_src1);       end
      6'd2: begin w_disp_valid = 1'b1; w_disp_name = "SRC_2"; w_disp_value = 32'(r_src2);       end
      6'd3: begin w_disp_valid = 1'b1; w_disp_name = "CONTR"; w_disp_value = 32'(r_ctrl);       end
      6'd4: begin w_disp_valid = 1'b1; w_disp_name = "RESUL"; w_disp_value = 32'(alu_result);   end
      6'd5: begin w_disp_valid = 1'b1; w_disp_name = "COUNT"; w_disp_value = 32'(r_cap_cnt);    end
      6'd6: begin w_disp_valid = 1'b1; w_disp_name = "HCNT "; w_disp_value = 32'(r_hist_count); end
      default: begin
        if (w_in_hist && (w_k < r_hist_count)) begin
          w_disp_valid = 1'b1;
          w_disp_name  = w_his_name;
          w_disp_value = 32'(r_hist[w_rd_idx]);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_disp_valid <= 1'b0;
      r_disp_name  <= '0;
      r_disp_value <= '0;
    end else begin
      r_disp_valid <= w_disp_valid;
      r_disp_name  <= w_disp_name;
      r_disp_value <= w_disp_value;
    end
  end

  assign display_valid = r_disp_valid;
  assign display_name  = r_disp_name;
  assign display_value = r_disp_value;
  assign alu_control   = r_ctrl;
  assign alu_src1      = r_src1;
  assign alu_src2      = r_src2;
  assign hist_count    = r_hist_count;

endmodule
`default_nettype wire

// File: doc/alu_console.md
Name: alu_console

Overview:
- Parametrised operator console between `lcd_module` (touchscreen I/O) and an external `alu` instance.
- Holds ALU operands and control code written from touchscreen input.
- Captures ALU results into a ring-buffer history, on a debounced-free push button or a touch command.
- Serves all values to the LCD display scan as registered name/value pairs.

Parameters:
- `DATA_W`, 32: operand/result width; legal range 8..32; values are zero-extended to 32 bits for display.
- `CTRL_W`, 5: ALU control-code width; legal range 1..32.
- `HIST_DEPTH`, 8: history entries; power of two, legal range 2..32.
- `CNT_W`, 16: width of the total-capture counter.

Ports:
- `clk`  in  1  system clock (10 MHz).
- `resetn`  in  1  synchronous, active-low reset.
- `input_sel`  in  2  target select: 00 = control, 01 = history command, 10 = src1, 11 = src2.
- `input_valid`  in  1  one-cycle strobe from `lcd_module`.
- `input_value`  in  32  touch-entered value.
- `capture_btn`  in  1  asynchronous push button, active high.
- `display_number`  in  6  display slot being scanned (1..44).
- `display_valid`  out  1  slot has content.
- `display_name`  out  40  5-character ASCII label.
- `display_value`  out  32  slot value.
- `alu_control`  out  CTRL_W  to ALU.
- `alu_src1`  out  DATA_W  to ALU.
- `alu_src2`  out  DATA_W  to ALU.
- `alu_result`  in  DATA_W  from ALU (combinational).
- `hist_count`  out  6  number of valid history entries (0..HIST_DEPTH).

Behaviour:
- Reset (`resetn` low at posedge clk), all cleared:
  - `alu_control`, `alu_src1`, `alu_src2` = 0.
  - `hist_count` = 0, write pointer = 0, capture counter = 0.
  - Synchroniser flops = 0.
  - `display_valid` = 0, `display_name` = 0, `display_value` = 0.
  - History RAM contents need not be cleared; they are masked by `hist_count`.
- Operand writes, on `input_valid` with:
  - sel 00: `alu_control` <= `input_value[CTRL_W-1:0]`.
  - sel 10: `alu_src1` <= `input_value[DATA_W-1:0]`.
  - sel 11: `alu_src2` <= `input_value[DATA_W-1:0]`.
  - Each takes effect on the next edge.
- Button path:
  - Two-flop synchroniser, then rising-edge detect on the synchronised signal.
  - Produces `btn_pulse` exactly 2 cycles after the button is sampled high.
  - One pulse per press; a held button produces no repeats.
- History commands (`input_valid` & sel 01):
  - `input_value` == 0: clear. `hist_count` <= 0, write pointer <= 0, capture counter <= 0.
  - `input_value` != 0: `cmd_capture`.
- Capture event = `btn_pulse` | `cmd_capture`. On that edge:
  - `hist[wr_ptr]` <= `alu_result` sampled that cycle.
  - `wr_ptr` <= `wr_ptr`+1 modulo HIST_DEPTH (wraps, overwriting the oldest entry).
  - `hist_count` <= min(`hist_count`+1, HIST_DEPTH), saturating.
  - Capture counter +1, wrapping at 2^CNT_W.
  - Simultaneous `btn_pulse` and `cmd_capture` = one capture only.
  - Clear and `btn_pulse` in the same cycle: clear wins; nothing is stored.
  - An operand write and `btn_pulse` in the same cycle: the result captured is from the pre-write operands.
- Display mux, registered, 1-cycle latency from `display_number`:
  - 1: "SRC_1", `alu_src1`.
  - 2: "SRC_2", `alu_src2`.
  - 3: "CONTR", `alu_control`.
  - 4: "RESUL", `alu_result`.
  - 5: "COUNT", capture counter.
  - 6: "HCNT ", `hist_count`.
  - 7..6+HIST_DEPTH, entry k = `display_number`-7 (k=0 newest):
    - Name "HIS" followed by two ASCII decimal digits of k (e.g. "HIS03").
    - Value `hist[(wr_ptr-1-k) mod HIST_DEPTH]`.
    - `display_valid` = 1 only if k < `hist_count`; otherwise `display_valid`=0, name=0, value=0.
  - All others (0, and numbers beyond 6+HIST_DEPTH): `display_valid`=0, name=0, value=0.
  - All numeric values are zero-extended to 32 bits.
- Reset asserted mid-capture: reset has priority; the capture is discarded.

Test Plan:
- Reset, then scan 1..44 → slots 1..6 valid with all-zero values; slots 7..44 have `display_valid`=0.
- Write src1=0x00000005 (sel 10), src2=0x00000003 (sel 11), control=0x01 (sel 00); ALU model returns src1+src2 → slot 4 shows 0x00000008 one cycle after `display_number`=4.
- Press button held for 50 cycles → exactly one capture.
  - `hist_count`=1, slot 7 "HIS00"=0x8, COUNT=1.
  - Second press with src1=0x10 → HIS00=0x13, HIS01=0x8.
- Issue 10 sel-01 captures of values 1..10 (via src1 updates, src2=0), HIST_DEPTH=8 → `hist_count`=8.
  - HIS00=10, HIS07=3 (wrap verified).
  - COUNT=10.
- Same cycle: `btn_pulse` plus sel-01 value 0 → history cleared, `hist_count`=0, COUNT=0, slot 7 invalid.
- Same cycle: `btn_pulse` plus sel-01 nonzero → COUNT increments by exactly 1.
